// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the data-memory stage: instruction codes,
// status codes, FSM states and the status-priority helper.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Address faults outrank illegal instructions, which outrank halt.
  function automatic logic [2:0] y86_status(input logic ierr, input logic derr,
                                            input logic iv, input logic [3:0] ic);
    if (ierr || derr) return SADR;
    if (!iv)          return SINS;
    if (ic == IHALT)  return SHLT;
    return SAOK;
  endfunction

endpackage

// File: rtl/y86_dmem_array.sv
// Single-port word array: synchronous write, registered read, no reset.
module y86_dmem_array #(
  parameter int DATA_W      = 64,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // rdata only moves on a read, so it stays stable while a response is held.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      else    rdata    <= mem[idx];
    end
  end

endmodule

// File: rtl/y86_dmem_unit.sv
// Handshaked Y86-64 data-memory stage: access decode, bounds/alignment check,
// latency FSM and sticky status reporting around a y86_dmem_array.
module y86_dmem_unit
  import y86_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  input  logic              instr_valid,
  input  logic              imem_error,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error,
  output logic [2:0]        stat
);

  localparam int BPW = DATA_W / 8;
  localparam int OB  = $clog2(BPW);
  localparam int AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              accept, done;

  logic              acc_we, acc_re, bad_addr, legal, acc_ok, req_fault;
  logic [DATA_W-1:0] acc_addr, acc_wdata, word;
  logic [2:0]        req_stat;

  logic              we_p0, re_p0, fault_p0;
  logic [2:0]        stat_p0;
  logic [AW-1:0]     idx_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              rd_q, stopped;
  logic [2:0]        stat_lat;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    acc_we    = 1'b0;
    acc_re    = 1'b0;
    acc_addr  = valE;
    acc_wdata = valA;
    case (icode)
      IRMMOVQ, IPUSHQ: acc_we = 1'b1;
      ICALL: begin
        acc_we    = 1'b1;
        acc_wdata = valP;
      end
      IMRMOVQ: acc_re = 1'b1;
      IRET, IPOPQ: begin
        acc_re   = 1'b1;
        acc_addr = valA;
      end
      default: ;
    endcase
  end

  // addr >= DEPTH_WORDS*BPW is equivalent to word index >= DEPTH_WORDS.
  assign word      = acc_addr >> OB;
  assign bad_addr  = (word >= DATA_W'(DEPTH_WORDS)) ||
                     ((ALIGN_CHECK != 0) && ((acc_addr & DATA_W'(BPW - 1)) != '0));
  // A fetch fault or illegal instruction never touches data memory.
  assign legal     = instr_valid && !imem_error;
  assign acc_ok    = legal && !bad_addr;
  assign req_fault = legal && (acc_we || acc_re) && bad_addr;
  assign req_stat  = y86_status(imem_error, req_fault, instr_valid, icode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (req_valid) begin
        state_nx = BUSY;
        cnt_nx   = CW'(LATENCY - 1);
      end
      BUSY: if (cnt == '0) state_nx = RESP;
            else           cnt_nx   = cnt - CW'(1);
      RESP: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    accept     = req_valid && (state == IDLE);
    done       = (state == BUSY) && (cnt == '0);
  end

  // ---- p0: request captured at accept ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p0    <= 1'b0;
      re_p0    <= 1'b0;
      fault_p0 <= 1'b0;
      stat_p0  <= SAOK;
    end else if (accept) begin
      we_p0    <= acc_we && acc_ok;
      re_p0    <= acc_re && acc_ok;
      fault_p0 <= req_fault;
      stat_p0  <= req_stat;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0   <= AW'(word);
      wdata_p0 <= acc_wdata;
    end
  end

  // ---- p1: access commits and response registers load on the final BUSY edge ----
  y86_dmem_array #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .en    (done && !stopped && (we_p0 || re_p0)),
    .we    (we_p0),
    .idx   (idx_p0),
    .wdata (wdata_p0),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= 1'b0;
      dmem_error <= 1'b0;
      stat       <= SAOK;
      stopped    <= 1'b0;
      stat_lat   <= SAOK;
    end else if (done) begin
      if (stopped) begin
        rd_q       <= 1'b0;
        dmem_error <= 1'b0;
        stat       <= stat_lat;
      end else begin
        rd_q       <= re_p0;
        dmem_error <= fault_p0;
        stat       <= stat_p0;
        if (stat_p0 != SAOK) begin
          stopped  <= 1'b1;
          stat_lat <= stat_p0;
        end
      end
    end
  end

  assign valM = rd_q ? rdata : '0;

endmodule

// File: tb/tb_y86_dmem_unit.sv
// Directed bench for y86_dmem_unit: three instances cover LATENCY=1 with and
// without alignment checking, and LATENCY=3 with held responses and resets.
module tb_y86_dmem_unit;

  localparam int DW    = 64;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  icode = 4'd1;
  logic [63:0] valA = '0, valE = '0, valP = '0;
  logic        instr_valid = 1'b1, imem_error = 1'b0;
  logic        rv [3];
  logic        rp [3];
  logic        req_ready [3];
  logic        resp_valid [3];
  logic [63:0] valM [3];
  logic        dmem_error [3];
  logic [2:0]  stat [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  y86_dmem_unit #(.DATA_W(DW), .DEPTH_WORDS(DEPTH), .LATENCY(1), .ALIGN_CHECK(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(req_ready[0]), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP), .instr_valid(instr_valid), .imem_error(imem_error),
    .resp_valid(resp_valid[0]), .resp_ready(rp[0]), .valM(valM[0]),
    .dmem_error(dmem_error[0]), .stat(stat[0]));

  y86_dmem_unit #(.DATA_W(DW), .DEPTH_WORDS(DEPTH), .LATENCY(1), .ALIGN_CHECK(0)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(req_ready[1]), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP), .instr_valid(instr_valid), .imem_error(imem_error),
    .resp_valid(resp_valid[1]), .resp_ready(rp[1]), .valM(valM[1]),
    .dmem_error(dmem_error[1]), .stat(stat[1]));

  y86_dmem_unit #(.DATA_W(DW), .DEPTH_WORDS(DEPTH), .LATENCY(3), .ALIGN_CHECK(1)) u2 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(req_ready[2]), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP), .instr_valid(instr_valid), .imem_error(imem_error),
    .resp_valid(resp_valid[2]), .resp_ready(rp[2]), .valM(valM[2]),
    .dmem_error(dmem_error[2]), .stat(stat[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_rdy", 64'(req_ready[s]), 64'd1);
      chk("rst_vld", 64'(resp_valid[s]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction on instance s; hold = cycles resp_ready stays low
  // after resp_valid rises, with outputs checked for stability each cycle.
  task automatic txn(input int s, input logic [3:0] ic, input logic [63:0] a,
                     input logic [63:0] e, input logic [63:0] p, input logic iv,
                     input logic ie, input int hold, input logic [63:0] xm,
                     input logic xe, input logic [2:0] xs, input string tag);
    int cyc;
    int lat;
    lat = (s == 2) ? 3 : 1;
    @(negedge clk);
    chk({tag, ":rdy_in"}, 64'(req_ready[s]), 64'd1);
    icode = ic; valA = a; valE = e; valP = p; instr_valid = iv; imem_error = ie;
    rv[s] = 1'b1;
    @(posedge clk);
    #1;
    rv[s] = 1'b0;
    icode = 4'hF; valA = '1; valE = '1; valP = '1; instr_valid = 1'b1; imem_error = 1'b0;
    cyc = 0;
    while (!resp_valid[s] && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ":lat"}, 64'(cyc), 64'(lat));
    chk({tag, ":valM"}, valM[s], xm);
    chk({tag, ":derr"}, 64'(dmem_error[s]), 64'(xe));
    chk({tag, ":stat"}, 64'(stat[s]), 64'(xs));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ":hold_vld"}, 64'(resp_valid[s]), 64'd1);
      chk({tag, ":hold_rdy"}, 64'(req_ready[s]), 64'd0);
      chk({tag, ":hold_valM"}, valM[s], xm);
      chk({tag, ":hold_stat"}, 64'(stat[s]), 64'(xs));
    end
    rp[s] = 1'b1;
    @(posedge clk);
    #1;
    rp[s] = 1'b0;
    chk({tag, ":vld_done"}, 64'(resp_valid[s]), 64'd0);
    chk({tag, ":rdy_done"}, 64'(req_ready[s]), 64'd1);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      rv[s] = 1'b0;
      rp[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("reset_rdy", 64'(req_ready[s]), 64'd1);
      chk("reset_vld", 64'(resp_valid[s]), 64'd0);
      chk("reset_valM", valM[s], 64'd0);
      chk("reset_derr", 64'(dmem_error[s]), 64'd0);
      chk("reset_stat", 64'(stat[s]), 64'd1);
    end
    @(negedge clk);
    rst = 1'b0;

    // LATENCY=1, alignment checked
    txn(0, 4'd4, 64'h1122334455667788, 64'h40, 64'h0, 1, 0, 0, 64'h0, 0, 3'd1, "rmmovq");
    txn(0, 4'd5, 64'h0, 64'h40, 64'h0, 1, 0, 0, 64'h1122334455667788, 0, 3'd1, "mrmovq");
    txn(0, 4'd8, 64'h0, 64'h100, 64'h2A, 1, 0, 0, 64'h0, 0, 3'd1, "call");
    txn(0, 4'd9, 64'h100, 64'h108, 64'h0, 1, 0, 0, 64'h2A, 0, 3'd1, "ret");
    txn(0, 4'd10, 64'hDEADBEEFCAFEF00D, 64'h1F8, 64'h0, 1, 0, 0, 64'h0, 0, 3'd1, "pushq");
    txn(0, 4'd11, 64'h1F8, 64'h200, 64'h0, 1, 0, 0, 64'hDEADBEEFCAFEF00D, 0, 3'd1, "popq");
    txn(0, 4'd4, 64'h77, 64'h0, 64'h0, 1, 0, 0, 64'h0, 0, 3'd1, "wr0");
    txn(0, 4'd5, 64'h0, 64'(DEPTH * 8), 64'h0, 1, 0, 0, 64'h0, 1, 3'd3, "oob");
    txn(0, 4'd4, 64'h99, 64'h0, 64'h0, 1, 0, 0, 64'h0, 0, 3'd3, "stopped_wr");
    do_reset();
    txn(0, 4'd5, 64'h0, 64'h0, 64'h0, 1, 0, 0, 64'h77, 0, 3'd1, "rd0_after");
    txn(0, 4'd4, 64'h55, 64'h43, 64'h0, 1, 0, 0, 64'h0, 1, 3'd3, "misalign");
    do_reset();
    txn(0, 4'd5, 64'h0, 64'h40, 64'h0, 1, 0, 0, 64'h1122334455667788, 0, 3'd1, "nowrite_mis");

    // LATENCY=1, alignment not checked: 0x43 lands in word 8
    txn(1, 4'd4, 64'hABCD, 64'h43, 64'h0, 1, 0, 0, 64'h0, 0, 3'd1, "mis_ok_wr");
    txn(1, 4'd5, 64'h0, 64'h40, 64'h0, 1, 0, 0, 64'hABCD, 0, 3'd1, "mis_ok_rd");

    // LATENCY=3 with a held response
    txn(2, 4'd4, 64'h1234, 64'h80, 64'h0, 1, 0, 5, 64'h0, 0, 3'd1, "hold_wr");
    txn(2, 4'd5, 64'h0, 64'h80, 64'h0, 1, 0, 0, 64'h1234, 0, 3'd1, "l3_rd");

    // Reset one cycle after accepting a write drops it
    @(negedge clk);
    icode = 4'd4; valE = 64'h80; valA = 64'h5555; rv[2] = 1'b1;
    @(posedge clk);
    #1;
    rv[2] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_vld", 64'(resp_valid[2]), 64'd0);
    chk("midrst_rdy", 64'(req_ready[2]), 64'd1);
    chk("midrst_stat", 64'(stat[2]), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_quiet", 64'(resp_valid[2]), 64'd0);
    end
    txn(2, 4'd5, 64'h0, 64'h80, 64'h0, 1, 0, 0, 64'h1234, 0, 3'd1, "midrst_rd");

    // Halt is sticky; illegal instruction and fetch fault statuses
    txn(2, 4'd0, 64'h0, 64'h0, 64'h0, 1, 0, 0, 64'h0, 0, 3'd2, "halt");
    txn(2, 4'd5, 64'h0, 64'h80, 64'h0, 1, 0, 0, 64'h0, 0, 3'd2, "halt_sticky");
    do_reset();
    txn(2, 4'd1, 64'h0, 64'h0, 64'h0, 0, 0, 0, 64'h0, 0, 3'd4, "ins");
    txn(2, 4'd0, 64'h0, 64'h0, 64'h0, 1, 0, 0, 64'h0, 0, 3'd4, "ins_sticky");
    do_reset();
    txn(2, 4'd1, 64'h0, 64'h0, 64'h0, 0, 1, 0, 64'h0, 0, 3'd3, "imem_err");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
